// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared mode, state and tuple definitions for the retire-trace buffer
package trace_pkg;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_FIFO = 2'd1;
    localparam logic [1:0] MODE_RING = 2'd2;
    localparam logic [1:0] MODE_TRIG = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_t;

    localparam int TRACE_PC_W   = 32;
    localparam int TRACE_INST_W = 32;
    localparam int TRACE_ADDR_W = 32;

    // Field order of one stored entry; the buffer packs its RAM words in this same order
    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_INST_W-1:0] inst;
        logic [TRACE_ADDR_W-1:0] addr;
    } trace_tuple_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace storage, one synchronous write port and one asynchronous read port
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entry contents need no reset: occupancy tracking decides what is readable
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - retire-trace capture buffer with fifo, ring and pc-trigger modes
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       cap_valid,
    input  logic [PC_W-1:0]            cap_pc,
    input  logic [INST_W-1:0]          cap_inst,
    input  logic [ADDR_W-1:0]          cap_addr,
    input  logic [1:0]                 mode,
    input  logic                       arm,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [PC_W-1:0]            rd_pc,
    output logic [INST_W-1:0]          rd_inst,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       triggered,
    output logic                       frozen
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = PC_W + INST_W + ADDR_W;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] POST_LOAD = CW'(POST_TRIG);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    trace_state_t      state;
    logic [1:0]        mode_q;
    logic [PC_W-1:0]   trig_pc_q;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     post_cnt;
    logic              overflow_q;
    logic              triggered_q;

    logic              running;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              overwrite;
    logic              trig_hit;
    logic [TW-1:0]     wr_data;
    logic [TW-1:0]     rd_data;

    // Per-cycle push/pop decisions; an arm cycle suppresses both
    always_comb begin
        running   = (state == ST_RUN) || (state == ST_POST);
        full      = (count_q == FULL_CNT);
        pop       = (count_q != '0) && rd_ready && !arm;
        drop      = running && cap_valid && !arm && full && !pop && (mode_q == MODE_FIFO);
        push      = running && cap_valid && !arm && !drop;
        // fifo never reaches here when full without a pop, so this is the ring/trigger case
        overwrite = push && full && !pop;
        trig_hit  = push && (state == ST_RUN) && (mode_q == MODE_TRIG) && (cap_pc == trig_pc_q);
    end

    assign wr_data = {cap_pc, cap_inst, cap_addr};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (TW)
    ) u_ram (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    // Control state machine, pointers, occupancy and sticky flags
    always_ff @(posedge clk_in) begin
        if (reset || arm) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            post_cnt    <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
            if (reset) begin
                state     <= ST_IDLE;
                mode_q    <= MODE_OFF;
                trig_pc_q <= '0;
            end else begin
                state     <= (mode != MODE_OFF) ? ST_RUN : ST_IDLE;
                mode_q    <= mode;
                trig_pc_q <= trig_pc;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop && !overwrite) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop || overwrite) begin
                overflow_q <= 1'b1;
            end

            case (state)
                ST_RUN: begin
                    if (trig_hit) begin
                        triggered_q <= 1'b1;
                        post_cnt    <= POST_LOAD;
                        state       <= (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
                    end
                end
                ST_POST: begin
                    if (push) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ONE_CNT) begin
                            state <= ST_FROZEN;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign rd_valid  = (count_q != '0);
    assign {rd_pc, rd_inst, rd_addr} = rd_data;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign frozen    = (state == ST_FROZEN);

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb/tb_trace_capture_buffer.sv - directed self-checking bench for trace_capture_buffer
module tb_trace_capture_buffer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cap_valid;
    logic [31:0] cap_pc;
    logic [31:0] cap_inst;
    logic [31:0] cap_addr;
    logic [1:0]  mode;
    logic        arm;
    logic [31:0] trig_pc;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_addr;
    logic [4:0]  count;
    logic        overflow;
    logic        triggered;
    logic        frozen;

    int errors = 0;
    int checks = 0;

    trace_capture_buffer #(
        .PC_W(32), .INST_W(32), .ADDR_W(32), .DEPTH(16), .POST_TRIG(4)
    ) dut (
        .clk_in(clk_in), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_inst(cap_inst), .cap_addr(cap_addr), .mode(mode), .arm(arm),
        .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_inst(rd_inst), .rd_addr(rd_addr), .count(count), .overflow(overflow),
        .triggered(triggered), .frozen(frozen)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_cap(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_inst  = ~pc;
        cap_addr  = pc + 32'h1000;
    endtask

    task automatic do_cap(input logic [31:0] pc);
        set_cap(pc);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [31:0] tp);
        arm = 1'b1; mode = m; trig_pc = tp;
        tick();
        arm = 1'b0; mode = 2'd0; trig_pc = 32'h0;
    endtask

    task automatic do_pop();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if ({overflow, triggered, frozen} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {overflow, triggered, frozen}); end
        do_arm(2'd0, 32'h0);
        for (int i = 0; i < 5; i++) do_cap(32'h100 + 32'(4 * i));
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] exp;
        do_arm(2'd1, 32'h0);
        do_cap(32'h0040_0000);
        checks++; if (rd_valid !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL fifo_first_latency: got valid=%b count=%0d expected valid=1 count=1", rd_valid, count); end
        for (int i = 1; i < 16; i++) do_cap(32'h0040_0000 + 32'(4 * i));
        checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL fifo_full: got count=%0d ov=%b expected 16/0", count, overflow); end
        do_cap(32'h0040_0040);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fifo_ovf_count: got %0d expected 16", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fifo_ovf_flag: got %b expected 1", overflow); end
        checks++; if (rd_pc !== 32'h0040_0000) begin errors++; $display("FAIL fifo_ovf_head: got %h expected 00400000", rd_pc); end
        for (int i = 0; i < 16; i++) begin
            exp = 32'h0040_0000 + 32'(4 * i);
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== exp || rd_inst !== ~exp || rd_addr !== exp + 32'h1000) begin
                errors++;
                $display("FAIL fifo_drain[%0d]: got v=%b pc=%h inst=%h addr=%h expected pc=%h inst=%h addr=%h",
                         i, rd_valid, rd_pc, rd_inst, rd_addr, exp, ~exp, exp + 32'h1000);
            end
            do_pop();
        end
        checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL fifo_empty: got v=%b count=%0d expected 0/0", rd_valid, count); end
    endtask

    task automatic test_fifo_full_push_pop();
        logic [31:0] last;
        do_arm(2'd1, 32'h0);
        for (int i = 0; i < 16; i++) do_cap(32'h800 + 32'(4 * i));
        set_cap(32'h900); rd_ready = 1'b1;
        tick();
        cap_valid = 1'b0; rd_ready = 1'b0;
        checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL fifo_pp_count: got count=%0d ov=%b expected 16/0", count, overflow); end
        checks++; if (rd_pc !== 32'h804) begin errors++; $display("FAIL fifo_pp_head: got %h expected 00000804", rd_pc); end
        last = 32'h0;
        for (int i = 0; i < 16; i++) begin last = rd_pc; do_pop(); end
        checks++; if (last !== 32'h900) begin errors++; $display("FAIL fifo_pp_last: got %h expected 00000900", last); end
    endtask

    task automatic test_ring_wrap();
        logic [31:0] exp;
        do_arm(2'd2, 32'h0);
        for (int i = 0; i < 20; i++) do_cap(32'(4 * i));
        checks++; if (count !== 5'd16 || overflow !== 1'b1) begin errors++; $display("FAIL ring_state: got count=%0d ov=%b expected 16/1", count, overflow); end
        checks++; if (rd_pc !== 32'h10) begin errors++; $display("FAIL ring_head: got %h expected 00000010", rd_pc); end
        for (int i = 0; i < 16; i++) begin
            exp = 32'h10 + 32'(4 * i);
            checks++; if (rd_pc !== exp) begin errors++; $display("FAIL ring_drain[%0d]: got %h expected %h", i, rd_pc, exp); end
            do_pop();
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ring_empty: got %b expected 0", rd_valid); end
    endtask

    task automatic test_ring_push_pop();
        do_arm(2'd2, 32'h0);
        for (int i = 0; i < 16; i++) do_cap(32'h100 + 32'(4 * i));
        set_cap(32'h200); rd_ready = 1'b1;
        tick();
        cap_valid = 1'b0; rd_ready = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ring_pp_count: got %0d expected 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ring_pp_overflow: got %b expected 0", overflow); end
        checks++; if (rd_pc !== 32'h104) begin errors++; $display("FAIL ring_pp_head: got %h expected 00000104", rd_pc); end
    endtask

    task automatic test_trigger();
        logic [31:0] last;
        do_arm(2'd3, 32'h0040_0020);
        for (int i = 0; i < 16; i++) begin
            do_cap(32'h0040_0000 + 32'(4 * i));
            if (i == 7) begin
                checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL trig_early: got %b expected 0", triggered); end
            end
            if (i == 8) begin
                checks++; if (triggered !== 1'b1 || frozen !== 1'b0) begin errors++; $display("FAIL trig_hit: got trig=%b frozen=%b expected 1/0", triggered, frozen); end
            end
            if (i == 11) begin
                checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL trig_post: got frozen=%b expected 0", frozen); end
            end
            if (i == 12) begin
                checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL trig_frozen: got frozen=%b expected 1", frozen); end
            end
        end
        checks++; if (count !== 5'd13) begin errors++; $display("FAIL trig_count: got %0d expected 13", count); end
        last = 32'h0;
        for (int i = 0; i < 13; i++) begin last = rd_pc; do_pop(); end
        checks++; if (last !== 32'h0040_0030) begin errors++; $display("FAIL trig_last: got %h expected 00400030", last); end
        checks++; if (rd_valid !== 1'b0 || frozen !== 1'b1) begin errors++; $display("FAIL trig_drained: got v=%b frozen=%b expected 0/1", rd_valid, frozen); end
    endtask

    task automatic test_rearm();
        do_arm(2'd3, 32'h8);
        for (int i = 0; i < 4; i++) do_cap(32'(4 * i));
        checks++; if (triggered !== 1'b1 || frozen !== 1'b0 || count !== 5'd4) begin errors++; $display("FAIL rearm_setup: got trig=%b frozen=%b count=%0d expected 1/0/4", triggered, frozen, count); end
        set_cap(32'hDEAD);
        arm = 1'b1; mode = 2'd1; trig_pc = 32'h0;
        tick();
        arm = 1'b0; cap_valid = 1'b0; mode = 2'd0;
        checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rearm_clear: got count=%0d v=%b expected 0/0", count, rd_valid); end
        checks++; if (triggered !== 1'b0 || overflow !== 1'b0 || frozen !== 1'b0) begin errors++; $display("FAIL rearm_flags: got %b expected 000", {triggered, overflow, frozen}); end
        do_cap(32'h55);
        checks++; if (count !== 5'd1 || rd_pc !== 32'h55) begin errors++; $display("FAIL rearm_run: got count=%0d pc=%h expected 1/00000055", count, rd_pc); end
    endtask

    task automatic test_mid_reset();
        do_arm(2'd3, 32'h8);
        for (int i = 0; i < 4; i++) do_cap(32'(4 * i));
        set_cap(32'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0; cap_valid = 1'b0;
        checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mreset_count: got count=%0d v=%b expected 0/0", count, rd_valid); end
        checks++; if ({overflow, triggered, frozen} !== 3'b000) begin errors++; $display("FAIL mreset_flags: got %b expected 000", {overflow, triggered, frozen}); end
        do_cap(32'h8); do_cap(32'hC);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mreset_idle: got %0d expected 0", count); end
    endtask

    initial begin
        reset = 1'b1; cap_valid = 1'b0; cap_pc = '0; cap_inst = '0; cap_addr = '0;
        mode = 2'd0; arm = 1'b0; trig_pc = '0; rd_ready = 1'b0;
        test_reset();
        test_fifo_overflow();
        test_fifo_full_push_pop();
        test_ring_wrap();
        test_ring_push_pop();
        test_trigger();
        test_rearm();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Parametrised retire-trace buffer for the CPU top level. It records per-instruction (pc, inst, addr) tuples in an on-chip buffer instead of exposing only the current cycle's values.
- It sits beside the CPU core in the top-level dataflow wrapper and is fed by the core's retire strobe.
- The bench or debug host drains it through a valid/ready read port.
- Supports FIFO, ring and PC-triggered capture modes.

Parameters:
- PC_W, 32, width of captured pc
- INST_W, 32, width of captured instruction word
- ADDR_W, 32, width of captured data-memory address
- DEPTH, 16, number of entries; power of two, >= 2
- POST_TRIG, 4, entries captured after the trigger entry in trigger mode; 0 <= POST_TRIG < DEPTH

Ports:
- clk_in  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- cap_valid  in  1  one instruction retires this cycle
- cap_pc  in  PC_W  retiring pc
- cap_inst  in  INST_W  retiring instruction
- cap_addr  in  ADDR_W  retiring data address
- mode  in  2  0=off, 1=fifo, 2=ring, 3=trigger; sampled only on arm
- arm  in  1  single-cycle pulse: clear buffer and start capture in mode
- trig_pc  in  PC_W  trigger address; sampled on arm
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  buffer non-empty
- rd_pc  out  PC_W  head entry pc
- rd_inst  out  INST_W  head entry instruction
- rd_addr  out  ADDR_W  head entry address
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: an entry was dropped or overwritten
- triggered  out  1  sticky: trigger entry captured
- frozen  out  1  capture finished (state FROZEN)

Behaviour:
Reset (synchronous):
- wr_ptr, rd_ptr and count are 0; state is IDLE.
- overflow, triggered and frozen are 0; rd_valid is 0.
- Latched mode is 0 and latched trig_pc is 0.
- rd_* data is don't-care while rd_valid is 0.
- Reset asserted mid-capture has exactly the same result.

States: IDLE, RUN, POST, FROZEN.

Arm:
- arm=1 in any state clears the pointers, count, overflow and triggered, and latches mode and trig_pc.
- Next state is RUN if the latched mode is non-zero, otherwise IDLE.
- A cap_valid or pop in the arm cycle is ignored.
- Changes to mode or trig_pc while running have no effect.

Capture:
- Occurs only in RUN or POST when cap_valid=1.
- The tuple is written at wr_ptr and wr_ptr increments modulo DEPTH.

Read:
- Show-ahead: rd_valid = (count != 0); rd_* reflects mem[rd_ptr] combinationally.
- A pop occurs when rd_valid && rd_ready; rd_ptr increments modulo DEPTH.
- Reads are legal in every state, including IDLE and FROZEN.

Full handling:
- fifo mode, full, no pop: the capture is dropped and overflow is set.
- fifo mode, full, with pop: the capture is accepted and count is unchanged.
- ring/trigger mode, full, no pop: the capture overwrites the oldest entry, rd_ptr advances by 1 and overflow is set.
- ring/trigger mode, full, with pop: the pop removes the oldest entry and the capture is written; rd_ptr advances once and count is unchanged; overflow is not set.
- Not full, push and pop together: count is unchanged.
- Empty with push: rd_valid rises the next cycle (write latency 1).

Trigger mode:
- In RUN, a capture with cap_pc == trig_pc sets triggered and loads the post counter with POST_TRIG.
- If POST_TRIG > 0, next state is POST; if POST_TRIG = 0, next state is FROZEN.
- In POST, each accepted capture decrements the counter; the capture that reaches 0 moves the state to FROZEN.
- FROZEN ignores cap_valid; frozen=1 in this state.
- Trigger matching applies only in RUN; a match in POST does not restart the counter.
- fifo and ring modes never leave RUN except via arm or reset.

Counter widths: count saturates logically at DEPTH. The pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package trace_pkg holds:
  - mode constants MODE_OFF, MODE_FIFO, MODE_RING, MODE_TRIG;
  - the 2-bit state encoding IDLE/RUN/POST/FROZEN;
  - a packed tuple typedef {pc, inst, addr}.
- Sub-module trace_ram: DEPTH x (PC_W+INST_W+ADDR_W), one synchronous write port, one asynchronous read port.
- Control, pointers and the state machine stay in trace_capture_buffer.

Test Plan:
- Reset then idle: after reset, arm with mode=0 and drive 5 captures -> count=0, rd_valid=0, overflow=0.
- fifo fill/overflow: arm mode=1; 17 captures with pc=0x00400000+4i, rd_ready=0 -> count=16, overflow=1, rd_pc=0x00400000. Drain all 16 -> pcs 0x00400000..0x0040003C in order, then rd_valid=0.
- ring wrap: arm mode=2; 20 captures pc=4i -> count=16, overflow=1, head rd_pc=0x10, last drained pc=0x4C.
- Full with simultaneous push/pop in ring: buffer full, one cycle with cap_valid=1 and rd_ready=1 -> count stays 16, overflow unchanged, next head is old second entry.
- Trigger: POST_TRIG=4, arm mode=3, trig_pc=0x00400020; captures pc=0x00400000+4i for i=0..15 -> triggered=1 at i=8, frozen=1 after i=12 capture; count=13; last drained pc=0x00400030.
- Re-arm and mid-op reset: in POST, assert arm with cap_valid=1 -> count=0, state RUN, capture ignored. Repeat in POST with reset=1 -> all outputs at reset values next cycle.
